// File: rtl/sf_pkg.sv
// Shared types and widths for the smoothing-filter peak detector.
package sf_pkg;

    // Sample and index widths shared with the upstream moving-average filter.
    localparam int DW = 16;
    localparam int IW = 10;

    typedef enum logic [1:0] {
        IDLE,
        BELOW,
        ABOVE
    } pd_state_t;

    typedef struct packed {
        logic [IW-1:0] index;
        logic [DW-1:0] value;
        logic [IW-1:0] width;
        logic          trunc;
    } peak_desc_t;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [IW-1:0] sat_inc(input logic [IW-1:0] v);
        return (v == '1) ? v : v + IW'(1);
    endfunction

endpackage

// File: rtl/sf_desc_fifo.sv
// Show-ahead FIFO of peak descriptors; head entry is visible without a pop.
module sf_desc_fifo
    import sf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  peak_desc_t push_data,
    input  logic       pop,
    output peak_desc_t head,
    output logic       full,
    output logic       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    peak_desc_t    mem [DEPTH];
    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   rd_ptr_reg;
    logic          wr_en;
    logic          rd_en;

    // Extra pointer bit distinguishes full from empty when the slot bits match.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // A pop frees the slot this cycle, so a full FIFO can still accept a push.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    // Head reads as zero while empty so stale storage never reaches the outputs.
    assign head = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

    // Storage array; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    // Read and write pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/sf_peak_detect.sv
// Hysteresis peak detector with minimum-width rule and descriptor FIFO.
module sf_peak_detect
    import sf_pkg::*;
#(
    parameter int MIN_WIDTH  = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_first,
    input  logic          in_last,
    input  logic [DW-1:0] thr_hi,
    input  logic [DW-1:0] thr_lo,
    output logic          peak_valid,
    input  logic          peak_ready,
    output logic [IW-1:0] peak_index,
    output logic [DW-1:0] peak_value,
    output logic [IW-1:0] peak_width,
    output logic          peak_trunc,
    output logic          frame_done,
    output logic [IW-1:0] peak_count,
    output logic          overflow
);

    localparam logic [IW-1:0] MIN_W = IW'(MIN_WIDTH);

    pd_state_t     state_reg, state_next, cur_state;
    logic [DW-1:0] thr_hi_reg, thr_hi_next, thr_lo_reg, thr_lo_next;
    logic [DW-1:0] hi_eff, lo_eff;
    logic [IW-1:0] index_reg, index_next, cur_idx;
    logic [IW-1:0] count_reg, count_next;
    logic [IW-1:0] width_reg, width_next;
    logic [IW-1:0] max_idx_reg, max_idx_next;
    logic [DW-1:0] max_reg, max_next;
    logic          overflow_reg, overflow_next;
    logic          frame_done_reg, frame_done_next;
    logic          push, pop, drop, full, empty;
    peak_desc_t    push_desc, head_desc;

    // Evaluate one sample: frame restart, run tracking, close/truncate and push.
    always_comb begin
        state_next      = state_reg;
        thr_hi_next     = thr_hi_reg;
        thr_lo_next     = thr_lo_reg;
        index_next      = index_reg;
        count_next      = count_reg;
        width_next      = width_reg;
        max_next        = max_reg;
        max_idx_next    = max_idx_reg;
        overflow_next   = overflow_reg;
        frame_done_next = 1'b0;
        push            = 1'b0;
        push_desc       = '0;
        cur_state       = state_reg;
        cur_idx         = index_reg;
        hi_eff          = thr_hi_reg;
        lo_eff          = thr_lo_reg;

        // A frame start overrides whatever was in progress, including an open run.
        if (in_valid && in_first) begin
            hi_eff        = thr_hi;
            lo_eff        = (thr_lo > thr_hi) ? thr_hi : thr_lo;
            thr_hi_next   = hi_eff;
            thr_lo_next   = lo_eff;
            cur_state     = BELOW;
            cur_idx       = '0;
            count_next    = '0;
            overflow_next = 1'b0;
        end

        if (in_valid && cur_state != IDLE) begin
            index_next = sat_inc(cur_idx);
            state_next = cur_state;
            case (cur_state)
                BELOW: begin
                    if (in_data > hi_eff) begin
                        state_next   = ABOVE;
                        width_next   = IW'(1);
                        max_next     = in_data;
                        max_idx_next = cur_idx;
                    end
                end
                ABOVE: begin
                    if (in_data >= lo_eff) begin
                        width_next = sat_inc(width_reg);
                        // Strict compare keeps the first occurrence of the maximum.
                        if (in_data > max_reg) begin
                            max_next     = in_data;
                            max_idx_next = cur_idx;
                        end
                    end else begin
                        // Exit sample is not part of the run.
                        state_next = BELOW;
                        if (width_reg >= MIN_W) begin
                            push      = 1'b1;
                            push_desc = '{index: max_idx_reg, value: max_reg,
                                          width: width_reg, trunc: 1'b0};
                        end
                    end
                end
                default: ;
            endcase

            // End of frame: a run still open after this sample is pushed as truncated.
            if (in_last) begin
                if (state_next == ABOVE && width_next >= MIN_W) begin
                    push      = 1'b1;
                    push_desc = '{index: max_idx_next, value: max_next,
                                  width: width_next, trunc: 1'b1};
                end
                state_next      = IDLE;
                frame_done_next = 1'b1;
            end
        end

        pop  = peak_ready && !empty;
        drop = push && full && !pop;
        if (push && !drop) count_next = sat_inc(count_next);
        if (drop) overflow_next = 1'b1;
    end

    // Detector state and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            thr_hi_reg     <= '0;
            thr_lo_reg     <= '0;
            index_reg      <= '0;
            count_reg      <= '0;
            width_reg      <= '0;
            max_reg        <= '0;
            max_idx_reg    <= '0;
            overflow_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            thr_hi_reg     <= thr_hi_next;
            thr_lo_reg     <= thr_lo_next;
            index_reg      <= index_next;
            count_reg      <= count_next;
            width_reg      <= width_next;
            max_reg        <= max_next;
            max_idx_reg    <= max_idx_next;
            overflow_reg   <= overflow_next;
            frame_done_reg <= frame_done_next;
        end
    end

    sf_desc_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_desc),
        .pop      (pop),
        .head     (head_desc),
        .full     (full),
        .empty    (empty)
    );

    assign peak_valid = !empty;
    assign peak_index = head_desc.index;
    assign peak_value = head_desc.value;
    assign peak_width = head_desc.width;
    assign peak_trunc = head_desc.trunc;
    assign frame_done = frame_done_reg;
    assign peak_count = count_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_sf_peak_detect.sv
// Randomised and directed bench for sf_peak_detect against a frame-level model.
module tb_sf_peak_detect;
    import sf_pkg::*;

    localparam int MIN_W  = 3;
    localparam int FIFO_D = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_first = 1'b0;
    logic          in_last = 1'b0;
    logic [DW-1:0] thr_hi = '0;
    logic [DW-1:0] thr_lo = '0;
    logic          peak_valid;
    logic          peak_ready = 1'b0;
    logic [IW-1:0] peak_index;
    logic [DW-1:0] peak_value;
    logic [IW-1:0] peak_width;
    logic          peak_trunc;
    logic          frame_done;
    logic [IW-1:0] peak_count;
    logic          overflow;

    int            n_compared = 0;
    int            n_mismatched = 0;
    int            ready_mode = 1;   // 0: held low, 1: held high, 2: random but high every other cycle
    logic          rnd_phase = 1'b0;
    peak_desc_t    exp_q[$];
    peak_desc_t    frame_peaks[$];
    logic [DW-1:0] smp[$];

    sf_peak_detect #(.MIN_WIDTH(MIN_W), .FIFO_DEPTH(FIFO_D)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_first(in_first), .in_last(in_last), .thr_hi(thr_hi), .thr_lo(thr_lo),
        .peak_valid(peak_valid), .peak_ready(peak_ready), .peak_index(peak_index),
        .peak_value(peak_value), .peak_width(peak_width), .peak_trunc(peak_trunc),
        .frame_done(frame_done), .peak_count(peak_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Every pop (sampled mid-cycle, taken at the next edge) must match the model queue.
    always @(negedge clk) begin
        if (!rst && peak_valid && peak_ready) begin
            check("pop_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                peak_desc_t d;
                d = exp_q.pop_front();
                check("pop_index", peak_index, d.index);
                check("pop_value", peak_value, d.value);
                check("pop_width", peak_width, d.width);
                check("pop_trunc", peak_trunc, d.trunc);
                $display("pop idx=%0d val=%0d w=%0d tr=%0d", peak_index, peak_value, peak_width, peak_trunc);
            end
        end
    end

    // Frame-level reference: scan the sample array for runs that start above hi
    // and end at the first sample below the effective lo.
    task automatic model_frame(input logic [DW-1:0] hi, input logic [DW-1:0] lo, input logic has_last);
        logic [DW-1:0] lo_e;
        peak_desc_t    d;
        int            i, j, n;
        frame_peaks.delete();
        lo_e = (lo > hi) ? hi : lo;
        n = smp.size();
        i = 0;
        while (i < n) begin
            if (smp[i] > hi) begin
                j = i + 1;
                while (j < n && smp[j] >= lo_e) j++;
                d.index = IW'(i);
                d.value = smp[i];
                d.width = IW'(j - i);
                d.trunc = (j >= n);
                for (int k = i + 1; k < j; k++) begin
                    if (smp[k] > d.value) begin
                        d.value = smp[k];
                        d.index = IW'(k);
                    end
                end
                if ((j - i) >= MIN_W && (j < n || has_last)) frame_peaks.push_back(d);
                i = j + 1;
            end else begin
                i++;
            end
        end
    endtask

    task automatic step(input logic v, input logic [DW-1:0] d, input logic f, input logic l,
                        input logic [DW-1:0] hi, input logic [DW-1:0] lo);
        in_valid = v; in_data = d; in_first = f; in_last = l; thr_hi = hi; thr_lo = lo;
        rnd_phase = ~rnd_phase;
        case (ready_mode)
            0:       peak_ready = 1'b0;
            1:       peak_ready = 1'b1;
            default: peak_ready = rnd_phase ? 1'b1 : 1'($urandom % 2);
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, DW'($urandom), 1'($urandom % 2), 1'($urandom % 2), DW'($urandom), DW'($urandom));
    endtask

    task automatic run_frame(input logic [DW-1:0] hi, input logic [DW-1:0] lo, input logic has_last,
                             input int gap_pct, input string name);
        int   stored;
        logic exp_ovf;
        model_frame(hi, lo, has_last);
        stored  = frame_peaks.size();
        exp_ovf = 1'b0;
        if (ready_mode == 0 && stored > FIFO_D) begin
            stored  = FIFO_D;
            exp_ovf = 1'b1;
        end
        for (int k = 0; k < stored; k++) exp_q.push_back(frame_peaks[k]);
        for (int i = 0; i < smp.size(); i++) begin
            while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) idle();
            if (i == 0) begin
                step(1'b1, smp[i], 1'b1, has_last && smp.size() == 1, hi, lo);
                check({name, "_ovf_clr"}, overflow, 0);
            end else begin
                step(1'b1, smp[i], 1'b0, has_last && i == smp.size() - 1, DW'($urandom), DW'($urandom));
            end
            if (i < smp.size() - 1) check({name, "_fd_low"}, frame_done, 0);
        end
        if (has_last) begin
            check({name, "_fd"}, frame_done, 1);
            check({name, "_count"}, peak_count, stored);
            check({name, "_ovf"}, overflow, exp_ovf);
        end else begin
            check({name, "_fd_abandon"}, frame_done, 0);
        end
        $display("frame %s n=%0d peaks=%0d stored=%0d fd=%0d cnt=%0d ovf=%0d",
                 name, smp.size(), frame_peaks.size(), stored, frame_done, peak_count, overflow);
    endtask

    task automatic drain(input string name);
        int budget = 0;
        ready_mode = 1;
        while (peak_valid && budget < 20) begin
            idle();
            budget++;
        end
        check({name, "_drained"}, peak_valid, 0);
    endtask

    initial begin
        logic [DW-1:0] hi, lo, lo_e;
        int            n;

        // Reset values, observed while reset is held.
        #2;
        check("rst_valid", peak_valid, 0);
        check("rst_fd", frame_done, 0);
        check("rst_ovf", overflow, 0);
        check("rst_count", peak_count, 0);
        check("rst_index", peak_index, 0);
        check("rst_value", peak_value, 0);
        check("rst_width", peak_width, 0);
        check("rst_trunc", peak_trunc, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Out of reset the detector waits for in_first; these samples must do nothing.
        ready_mode = 1;
        for (int i = 0; i < 5; i++) step(1'b1, 16'd500, 1'b0, i == 4, 16'd10, 16'd5);
        check("idle_fd", frame_done, 0);
        idle();
        check("idle_valid", peak_valid, 0);

        smp = '{16'd50, 16'd120, 16'd150, 16'd140, 16'd90, 16'd70};
        run_frame(16'd100, 16'd80, 1'b1, 0, "single");
        check("single_idx", peak_index, 2);
        check("single_val", peak_value, 150);
        check("single_w", peak_width, 4);
        check("single_tr", peak_trunc, 0);
        drain("single");

        smp = '{16'd50, 16'd120, 16'd130, 16'd60, 16'd55};
        run_frame(16'd100, 16'd80, 1'b1, 0, "short");
        drain("short");

        smp = '{16'd90, 16'd110, 16'd85, 16'd105, 16'd79, 16'd60};
        run_frame(16'd100, 16'd80, 1'b1, 0, "hyst");
        drain("hyst");

        smp = '{16'd50, 16'd60, 16'd120, 16'd130, 16'd140};
        run_frame(16'd100, 16'd80, 1'b1, 0, "trunc");
        check("trunc_val", peak_value, 140);
        check("trunc_w", peak_width, 3);
        check("trunc_tr", peak_trunc, 1);
        drain("trunc");

        // thr_lo above thr_hi collapses to thr_hi.
        smp = '{16'd50, 16'd120, 16'd110, 16'd105, 16'd99, 16'd50};
        run_frame(16'd100, 16'd200, 1'b1, 0, "lo_gt_hi");
        drain("lo_gt_hi");

        // Five valid peaks with the consumer stalled: four stored, one dropped.
        ready_mode = 0;
        smp.delete();
        smp.push_back(16'd50);
        for (int k = 0; k < 5; k++) begin
            smp.push_back(DW'(110 + k));
            smp.push_back(DW'(130 + k));
            smp.push_back(DW'(120 + k));
            smp.push_back(16'd50);
        end
        run_frame(16'd100, 16'd80, 1'b1, 0, "ovf");
        check("ovf_valid", peak_valid, 1);
        drain("ovf");

        // Frame abandoned while a run is open, then a normal frame.
        smp = '{16'd50, 16'd120, 16'd130, 16'd60, 16'd125, 16'd135, 16'd145, 16'd150};
        run_frame(16'd100, 16'd80, 1'b0, 0, "abandon");
        smp = '{16'd40, 16'd200, 16'd210, 16'd190, 16'd30};
        run_frame(16'd100, 16'd80, 1'b1, 0, "after_abandon");
        drain("after_abandon");

        // Random frames with idle gaps and a randomly stalling consumer.
        ready_mode = 2;
        for (int f = 0; f < 30; f++) begin
            hi = DW'($urandom_range(1500, 500));
            lo = ($urandom % 6 == 0) ? hi + DW'($urandom_range(50, 1)) : hi - DW'($urandom_range(300, 0));
            lo_e = (lo > hi) ? hi : lo;
            n = $urandom_range(40, 5);
            smp.delete();
            for (int k = 0; k < n; k++) smp.push_back(DW'($urandom_range(int'(hi) + 300, int'(lo_e) - 150)));
            run_frame(hi, lo, ($urandom % 8) != 0, 20, $sformatf("rnd%0d", f));
        end
        drain("rnd");

        // Asynchronous reset mid-run with two descriptors queued.
        ready_mode = 0;
        smp = '{16'd50, 16'd120, 16'd130, 16'd140, 16'd50, 16'd121, 16'd131, 16'd141, 16'd50, 16'd122, 16'd132};
        for (int i = 0; i < smp.size(); i++) step(1'b1, smp[i], i == 0, 1'b0, 16'd100, 16'd80);
        check("arst_pre_valid", peak_valid, 1);
        check("arst_pre_count", peak_count, 2);
        #3;
        rst = 1'b1;
        #1;
        check("arst_valid", peak_valid, 0);
        check("arst_count", peak_count, 0);
        check("arst_index", peak_index, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, 16'd300, 1'b0, i == 3, 16'd100, 16'd80);
        check("arst_ignore_fd", frame_done, 0);
        idle();
        check("arst_ignore_valid", peak_valid, 0);

        smp = '{16'd50, 16'd120, 16'd150, 16'd140, 16'd90, 16'd70};
        run_frame(16'd100, 16'd80, 1'b1, 0, "recover");
        drain("recover");

        check("exp_left", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
